draw_scheduler: RTL and testbench
=================================

# draw_scheduler

Arbitrates and sequences all sprite drawing for the Connect Four VGA front end. Two requesters share the single VGA adapter plot port: the column-pointer mover and the piece-drop logic. Each accepted job becomes a burst of 4x4-pixel writes (x, y, colour, plot). A pointer move first erases the old pointer sprite, then draws the new one.

## Interface
- BOX_LOG2, 2: log2 of sprite edge; sprite is 4x4 = 16 pixels
- PITCH, 16: pixel pitch between board columns/rows
- X0, 24: x of column 0 left edge
- Y0, 16: y of row 5 (top row) top edge
- PTR_Y, 4: y of pointer sprite top edge
- C_P0, 3'b100 / C_P1, 3'b110 / C_PTR, 3'b111 / C_BG, 3'b000: player 0, player 1, pointer and background colours

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- ptr_req  in  1  pointer-move request; held until ptr_ack
- ptr_col  in  3  target pointer column, 0-6
- ptr_ack  out  1  one-cycle pulse; ptr_col captured
- piece_req  in  1  piece-draw request; held until piece_ack
- piece_col  in  3  column 0-6
- piece_row  in  3  row 0-5, 0 = bottom
- piece_player  in  1  0 = player 0, 1 = player 1
- piece_ack  out  1  one-cycle pulse; piece fields captured
- x  out  8  VGA x coordinate
- y  out  7  VGA y coordinate
- colour  out  3  VGA colour
- plot  out  1  VGA write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of each job

## Operation
- States: IDLE, LOAD, ERASE, DRAW, FINISH. Registers: job type, captured fields, pix_cnt[3:0], cur_ptr[2:0], last_grant.
- IDLE: if any req is high, grant one request and go to LOAD. The granted requester's ack is high during LOAD.
- Arbitration is round-robin:
  - Both requests high: grant the type not equal to last_grant.
  - One request high: grant it.
  - last_grant updates on each grant.
- LOAD transitions, with pix_cnt cleared:
  - Piece with col>6 or row>5: FINISH (no plot).
  - Pointer with col>6: FINISH (no plot, cur_ptr unchanged).
  - Pointer with col == cur_ptr: DRAW.
  - Other pointer: ERASE.
  - Other piece: DRAW.
- ERASE: plot=1, colour=C_BG, sprite at cur_ptr. After pix_cnt==15: load cur_ptr with the captured column, clear pix_cnt, go to DRAW.
- DRAW: plot=1.
  - Piece: colour is C_P0 or C_P1 per the captured player.
  - Pointer: colour = C_PTR, drawn at cur_ptr.
  - After pix_cnt==15: go to FINISH.
- FINISH: done=1, go to IDLE.
- Pixel addressing, raster order:
  - px = pix_cnt[1:0], py = pix_cnt[3:2].
  - Pointer: x = X0 + col*PITCH + px; y = PTR_Y + py.
  - Piece: x as above; y = Y0 + (5-row)*PITCH + py.
- Arithmetic width rules: compute x in 9 bits and y in 8 bits, then truncate. Default parameters keep all coordinates in range (x ≤ 123, y ≤ 99).
- x, y and colour hold their last values when plot=0.
- Requests are not sampled outside IDLE. A req held through a job is served later and is not lost.

## Timing
- Reset values: state=IDLE, cur_ptr=3, last_grant=piece, pix_cnt=0. All outputs are 0 (x, y, colour, plot, acks, busy, done).
- Reset mid-job: the next cycle is IDLE with plot=0, no done and no ack. cur_ptr returns to 3. Partial sprites are left on screen; the top level clears them.
- All outputs are Moore, decoded from registered state. There is no combinational req-to-ack path.
- Piece job (req sampled high in IDLE at edge 0):
  - Cycle 1: LOAD, ack.
  - Cycles 2-17: DRAW, 16 plots.
  - Cycle 18: FINISH, done.
  - Cycle 19: IDLE.
  - Earliest next grant at edge 19.
- Pointer job, new column: LOAD in cycle 1, ERASE in 2-17, DRAW in 18-33, done in cycle 34.
- Pointer job, same column: 18 cycles, like a piece job.
- Invalid job: LOAD in cycle 1, done in cycle 2, no plot.
- A requester deasserts req the cycle after ack. A req still high in the IDLE cycle after FINISH is treated as a new request.

## Test plan
- Reset, then piece_req with col=0, row=0, player=1:
  - piece_ack in cycle 1.
  - 16 plots, colour 3'b110, x 24..27, y 96..99, raster order.
  - done in cycle 18.
- ptr_req col=6 from reset:
  - 16 plots C_BG at x 72..75, y 4..7.
  - Then 16 plots C_PTR at x 120..123.
  - done in cycle 34; cur_ptr=6.
- ptr_req col=3 after reset:
  - No ERASE; 16 C_PTR plots at x 72..75.
  - done in cycle 18.
- ptr_req and piece_req rise in the same cycle, both held:
  - Piece is served first, then pointer.
  - Repeat with both held continuously: grants alternate.
- piece_req with row=6, and separately ptr_req with col=7:
  - ack, then done 1 cycle later, zero plots.
  - cur_ptr unchanged.
- Assert reset during ERASE, pix_cnt=8:
  - plot=0 and busy=0 next cycle, no done.
  - A subsequent ptr col=3 request draws with no ERASE (cur_ptr=3).

Source files
------------

// File: rtl/draw_scheduler.sv
// Sprite draw scheduler for the Connect Four VGA front end.
// Round-robin arbitrates pointer-move and piece-draw jobs onto the single
// VGA plot port. Each job is a burst of 4x4-pixel writes. A pointer move
// first erases the old pointer sprite, then draws the new one.
module draw_scheduler #(
    parameter int unsigned BOX_LOG2 = 2,
    parameter int unsigned PITCH    = 16,
    parameter int unsigned X0       = 24,
    parameter int unsigned Y0       = 16,
    parameter int unsigned PTR_Y    = 4,
    parameter logic [2:0]  C_P0     = 3'b100,
    parameter logic [2:0]  C_P1     = 3'b110,
    parameter logic [2:0]  C_PTR    = 3'b111,
    parameter logic [2:0]  C_BG     = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ptr_req,
    input  logic [2:0] ptr_col,
    output logic       ptr_ack,
    input  logic       piece_req,
    input  logic [2:0] piece_col,
    input  logic [2:0] piece_row,
    input  logic       piece_player,
    output logic       piece_ack,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PixBits = 2 * BOX_LOG2;
    localparam logic [PixBits-1:0] PixLast = '1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StErase  = 3'd2;
    localparam logic [2:0] StDraw   = 3'd3;
    localparam logic [2:0] StFinish = 3'd4;

    localparam logic JobPtr   = 1'b0;
    localparam logic JobPiece = 1'b1;

    logic [2:0]         state_q, state_d;
    logic               job_q, job_d;
    logic [2:0]         col_q, col_d;
    logic [2:0]         row_q, row_d;
    logic               player_q, player_d;
    logic [PixBits-1:0] pix_cnt_q, pix_cnt_d;
    logic [2:0]         cur_ptr_q, cur_ptr_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_piece;

    // Last plotted pixel, held on the port while plot is low.
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;

    logic [2:0] sprite_col;
    logic [7:0] x_pix;
    logic [6:0] y_pix;
    logic [2:0] colour_pix;
    logic       piece_sprite;

    // Next-state: arbitration in IDLE, job dispatch in LOAD, pixel stepping.
    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        col_d        = col_q;
        row_d        = row_q;
        player_d     = player_q;
        pix_cnt_d    = pix_cnt_q;
        cur_ptr_d    = cur_ptr_q;
        last_grant_d = last_grant_q;
        grant_piece  = 1'b0;
        case (state_q)
            StIdle: begin
                if (ptr_req || piece_req) begin
                    // Both pending: favour whichever type was not granted last.
                    grant_piece  = (ptr_req && piece_req) ? (last_grant_q == JobPtr) : piece_req;
                    job_d        = grant_piece;
                    last_grant_d = grant_piece;
                    col_d        = grant_piece ? piece_col : ptr_col;
                    row_d        = piece_row;
                    player_d     = piece_player;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                pix_cnt_d = '0;
                if (job_q == JobPiece) begin
                    state_d = (col_q > 3'd6 || row_q > 3'd5) ? StFinish : StDraw;
                end else if (col_q > 3'd6) begin
                    state_d = StFinish;
                end else if (col_q == cur_ptr_q) begin
                    state_d = StDraw;
                end else begin
                    state_d = StErase;
                end
            end
            StErase: begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                if (pix_cnt_q == PixLast) begin
                    cur_ptr_d = col_q;
                    pix_cnt_d = '0;
                    state_d   = StDraw;
                end
            end
            StDraw: begin
                pix_cnt_d = pix_cnt_q + 1'b1;
                if (pix_cnt_q == PixLast) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            job_q        <= JobPtr;
            col_q        <= '0;
            row_q        <= '0;
            player_q     <= 1'b0;
            pix_cnt_q    <= '0;
            cur_ptr_q    <= 3'd3;
            last_grant_q <= JobPiece;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            job_q        <= job_d;
            col_q        <= col_d;
            row_q        <= row_d;
            player_q     <= player_d;
            pix_cnt_q    <= pix_cnt_d;
            cur_ptr_q    <= cur_ptr_d;
            last_grant_q <= last_grant_d;
            if (plot) begin
                x_q      <= x_pix;
                y_q      <= y_pix;
                colour_q <= colour_pix;
            end
        end
    end

    // Pixel address and colour for the current raster position.
    always_comb begin
        piece_sprite = (job_q == JobPiece);
        sprite_col   = (state_q == StDraw && piece_sprite) ? col_q : cur_ptr_q;
        x_pix = 8'(9'(X0) + 9'(sprite_col) * 9'(PITCH) + 9'(pix_cnt_q[BOX_LOG2-1:0]));
        if (state_q == StDraw && piece_sprite) begin
            y_pix = 7'(8'(Y0) + (8'd5 - 8'(row_q)) * 8'(PITCH)
                      + 8'(pix_cnt_q[PixBits-1:BOX_LOG2]));
        end else begin
            y_pix = 7'(8'(PTR_Y) + 8'(pix_cnt_q[PixBits-1:BOX_LOG2]));
        end
        if (state_q == StErase) begin
            colour_pix = C_BG;
        end else if (piece_sprite) begin
            colour_pix = player_q ? C_P1 : C_P0;
        end else begin
            colour_pix = C_PTR;
        end
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        plot      = (state_q == StErase) || (state_q == StDraw);
        busy      = (state_q != StIdle);
        done      = (state_q == StFinish);
        ptr_ack   = (state_q == StLoad) && (job_q == JobPtr);
        piece_ack = (state_q == StLoad) && (job_q == JobPiece);
        x         = plot ? x_pix : x_q;
        y         = plot ? y_pix : y_q;
        colour    = plot ? colour_pix : colour_q;
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: directed jobs followed by random
// request mixes, all checked against a job-level reference model.
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       ptr_req = 1'b0;
    logic [2:0] ptr_col = '0;
    logic       ptr_ack;
    logic       piece_req = 1'b0;
    logic [2:0] piece_col = '0;
    logic [2:0] piece_row = '0;
    logic       piece_player = 1'b0;
    logic       piece_ack;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_ptr;
    bit m_last_piece;
    int m_x, m_y, m_c;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    draw_scheduler dut (
        .clk(clk),
        .reset(reset),
        .ptr_req(ptr_req),
        .ptr_col(ptr_col),
        .ptr_ack(ptr_ack),
        .piece_req(piece_req),
        .piece_col(piece_col),
        .piece_row(piece_row),
        .piece_player(piece_player),
        .piece_ack(piece_ack),
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr        = 3;
        m_last_piece = 1'b1;
        m_x          = 0;
        m_y          = 0;
        m_c          = 0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_plot"}, plot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ptr_ack"}, ptr_ack, 0);
        chk({tag, "_piece_ack"}, piece_ack, 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ptr_req   = 1'b0;
        piece_req = 1'b0;
        @(posedge clk); #1;
        check_quiet("rst");
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Serve one job from the current request inputs; abort_at >= 0 asserts
    // reset while that pixel index of the burst is on the port.
    task automatic do_job(input int abort_at);
        pix_t q[$];
        bit   g_piece;
        int   col, row, c;
        @(posedge clk); #1;
        g_piece      = (ptr_req && piece_req) ? !m_last_piece : piece_req;
        m_last_piece = g_piece;
        chk("load_piece_ack", piece_ack, g_piece);
        chk("load_ptr_ack", ptr_ack, !g_piece);
        chk("load_busy", busy, 1);
        chk("load_plot", plot, 0);
        chk("load_done", done, 0);
        if (g_piece) begin
            col       = piece_col;
            row       = piece_row;
            c         = piece_player ? 6 : 4;
            piece_req = 1'b0;
            if (col <= 6 && row <= 5)
                for (int i = 0; i < 16; i++)
                    q.push_back('{24 + col * 16 + i % 4, 16 + (5 - row) * 16 + i / 4, c});
        end else begin
            col     = ptr_col;
            ptr_req = 1'b0;
            if (col <= 6) begin
                if (col != m_ptr) begin
                    for (int i = 0; i < 16; i++)
                        q.push_back('{24 + m_ptr * 16 + i % 4, 4 + i / 4, 0});
                    m_ptr = col;
                end
                for (int i = 0; i < 16; i++)
                    q.push_back('{24 + m_ptr * 16 + i % 4, 4 + i / 4, 7});
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            chk("pix_plot", plot, 1);
            chk("pix_x", x, q[i].x);
            chk("pix_y", y, q[i].y);
            chk("pix_colour", colour, q[i].c);
            chk("pix_done", done, 0);
            m_x = q[i].x;
            m_y = q[i].y;
            m_c = q[i].c;
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check_quiet("abort");
                chk("abort_x", x, 0);
                reset = 1'b0;
                model_reset();
                return;
            end
        end
        @(posedge clk); #1;
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_plot", plot, 0);
        chk("fin_x_hold", x, m_x);
        chk("fin_y_hold", y, m_y);
        chk("fin_colour_hold", colour, m_c);
        @(posedge clk); #1;
        check_quiet("idle");
    endtask

    initial begin
        model_reset();
        do_reset();

        // Piece col 0 row 0 player 1.
        piece_col = 3'd0; piece_row = 3'd0; piece_player = 1'b1; piece_req = 1'b1;
        do_job(-1);

        // Pointer to column 6 from reset: erase at 3, draw at 6.
        do_reset();
        ptr_col = 3'd6; ptr_req = 1'b1;
        do_job(-1);

        // Pointer to column 3 from reset: no erase.
        do_reset();
        ptr_col = 3'd3; ptr_req = 1'b1;
        do_job(-1);

        // Both at once after a pointer grant: piece then pointer.
        piece_col = 3'd4; piece_row = 3'd2; piece_player = 1'b0; piece_req = 1'b1;
        ptr_col = 3'd1; ptr_req = 1'b1;
        do_job(-1);
        do_job(-1);

        // Invalid jobs: no plots, pointer position unchanged.
        piece_col = 3'd2; piece_row = 3'd6; piece_req = 1'b1;
        do_job(-1);
        ptr_col = 3'd7; ptr_req = 1'b1;
        do_job(-1);
        ptr_col = 3'd1; ptr_req = 1'b1;
        do_job(-1);

        // Reset mid-erase at pixel 8, then a column-3 move draws without erase.
        do_reset();
        ptr_col = 3'd5; ptr_req = 1'b1;
        do_job(8);
        ptr_col = 3'd3; ptr_req = 1'b1;
        do_job(-1);

        // Random request mixes; ungranted requests stay held.
        for (int n = 0; n < 40; n++) begin
            if (!ptr_req && $urandom_range(0, 1) == 1) begin
                ptr_col = 3'($urandom_range(0, 7));
                ptr_req = 1'b1;
            end
            if (!piece_req && $urandom_range(0, 1) == 1) begin
                piece_col    = 3'($urandom_range(0, 7));
                piece_row    = 3'($urandom_range(0, 7));
                piece_player = 1'($urandom_range(0, 1));
                piece_req    = 1'b1;
            end
            if (!ptr_req && !piece_req) begin
                ptr_col = 3'($urandom_range(0, 6));
                ptr_req = 1'b1;
            end
            do_job(-1);
        end
        ptr_req   = 1'b0;
        piece_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
